alu_control: RTL and testbench
==============================

Name: alu_control

Overview:
- Decodes the 2-bit ALUOp from the main control unit and the 6-bit function/opcode selector into the 4-bit ALU operation code.
- Sits between the control FSM and the ALU in the multi-cycle MIPS datapath.
- Output is registered: one clock of latency, asynchronous active-low reset.
- Also flags unsupported function codes.

Parameters:
- None. All widths and codes are fixed by the shared package.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  function/operation selector; only meaningful when ALUOp = 2
- ALUOp  input  2  operation class from main control
- ALUInp  output  4  ALU operation code, registered
- illegal  output  1  registered; 1 when ALUOp = 2 and opcode is unsupported

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n = 0: ALUInp = 4'b0010 (ADD) and illegal = 0, immediately, independent of clk.
  - After rst_n deasserts, the first rising edge of clk loads the decoded value.
- Latency: the next-state value is a pure combinational decode of the current (ALUOp, opcode). It is captured on every rising clk edge. ALUInp and illegal reflect the inputs sampled at the previous edge.
  - No enable and no handshake.
  - An input change between edges has no effect until the next edge.
- ALU operation codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011
  - SUB 0110, SLT 0111
  - SLL 1000, SRL 1001, SRA 1010
  - NOR 1100
- Decode by ALUOp:
  - ALUOp = 0: ADD (loads, stores, address and PC arithmetic); opcode ignored; illegal = 0.
  - ALUOp = 1: SUB (beq/bne compare); opcode ignored; illegal = 0.
  - ALUOp = 2: R-type, decode opcode:
    - 0 → ADD, 1 → SUB, 2 → AND, 3 → OR, 4 → XOR
    - 5 → NOR, 6 → SLT, 7 → SLL, 8 → SRL, 9 → SRA
  - ALUOp = 2 with opcode 10..63: ALUInp = ADD and illegal = 1.
  - ALUOp = 3: SLT (set-less-than immediate); opcode ignored; illegal = 0.
- No X propagation: every input combination maps to a defined output.
- Reset asserted mid-operation forces the reset values at once.
- On reset release, the first active edge loads the decode of the inputs present at that edge.

Decomposition:
- Package alu_pkg holds:
  - 4-bit ALU operation code constants (ALU_AND … ALU_NOR)
  - 2-bit ALUOp constants (ALUOP_ADD = 0, ALUOP_SUB = 1, ALUOP_RTYPE = 2, ALUOP_SLT = 3)
  - function selector constants 0..9
  - The ALU itself imports the same operation-code constants.
- One natural sub-module: alu_func_decode, purely combinational, mapping opcode to {code, illegal} for R-type.
- The top level does the ALUOp mux and the output register.

Test Plan:
- Reset: rst_n = 0 with ALUOp = 1 while toggling clk → ALUInp = 0010 and illegal = 0 throughout. After release, the first edge → ALUInp = 0110.
- Fixed classes: opcode = 0; ALUOp = 0, then 1, then 3, each held 4 cycles → ALUInp = 0010, 0110, 0111 one cycle after each change; illegal = 0. Repeat with opcode = 37 → identical results.
- R-type sweep: ALUOp = 2, opcode stepped 0..9 one per cycle → ALUInp one cycle later = 0010, 0110, 0000, 0001, 0011, 1100, 0111, 1000, 1001, 1010; illegal = 0.
- Illegal codes: ALUOp = 2, opcode = 10, 32, 63 → ALUInp = 0010 and illegal = 1. Then ALUOp = 0 → illegal returns to 0 one cycle later.
- Latency and glitch check: change opcode twice between two clk edges → only the value present at the edge appears on ALUInp, one cycle after that edge.
- Asynchronous reset mid-stream: during the R-type sweep at opcode = 4, pulse rst_n low between edges → ALUInp drops to 0010 immediately, without waiting for clk. Decode resumes on the first edge after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALU operation codes, ALUOp classes and R-type function selectors.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_NOR = 4'b1100
  } alu_code_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_RTYPE = 2'd2,
    ALUOP_SLT   = 2'd3
  } aluop_t;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_OR  = 6'd3;
  localparam logic [5:0] FN_XOR = 6'd4;
  localparam logic [5:0] FN_NOR = 6'd5;
  localparam logic [5:0] FN_SLT = 6'd6;
  localparam logic [5:0] FN_SLL = 6'd7;
  localparam logic [5:0] FN_SRL = 6'd8;
  localparam logic [5:0] FN_SRA = 6'd9;

endpackage

// File: rtl/alu_control_if.sv
// Control-unit to ALU-control bus: operation class and selector in, ALU code and illegal flag out.
interface alu_control_if;
  logic [5:0] opcode;
  logic [1:0] ALUOp;
  logic [3:0] ALUInp;
  logic       illegal;

  modport master (output opcode, output ALUOp, input ALUInp, input illegal);
  modport slave  (input opcode, input ALUOp, output ALUInp, output illegal);
endinterface

// File: rtl/alu_control_func_decode.sv
// Combinational R-type function decode; unsupported selectors fall back to ADD and raise illegal.
module alu_func_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [3:0] code,
  output logic       illegal
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_XOR:  code = ALU_XOR;
      FN_NOR:  code = ALU_NOR;
      FN_SLT:  code = ALU_SLT;
      FN_SLL:  code = ALU_SLL;
      FN_SRL:  code = ALU_SRL;
      FN_SRA:  code = ALU_SRA;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control: selects the ALU code by ALUOp class and registers it with one cycle of latency.
module alu_control
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_control_if.slave  bus
);

  logic [3:0] func_code;
  logic       func_illegal;
  logic [3:0] code_p0;
  logic       illegal_p0;
  logic [3:0] code_p1;
  logic       illegal_p1;

  alu_func_decode u_func_decode (
    .opcode  (bus.opcode),
    .code    (func_code),
    .illegal (func_illegal)
  );

  // Stage p0: class mux, selector only consulted for R-type
  always_comb begin
    code_p0    = ALU_ADD;
    illegal_p0 = 1'b0;
    case (bus.ALUOp)
      ALUOP_ADD:   code_p0 = ALU_ADD;
      ALUOP_SUB:   code_p0 = ALU_SUB;
      ALUOP_RTYPE: begin
        code_p0    = func_code;
        illegal_p0 = func_illegal;
      end
      ALUOP_SLT:   code_p0 = ALU_SLT;
      default:     code_p0 = ALU_ADD;
    endcase
  end

  // Stage p1: registered output, reset value is ADD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_p1    <= ALU_ADD;
      illegal_p1 <= 1'b0;
    end else begin
      code_p1    <= code_p0;
      illegal_p1 <= illegal_p0;
    end
  end

  assign bus.ALUInp  = code_p1;
  assign bus.illegal = illegal_p1;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: vector table through a scoreboard plus reset and glitch sequences.
module tb_alu_control;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_control_if bus ();

  alu_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string      name;
    logic [1:0] aluop;
    logic [5:0] opc;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [3:0] code, input logic ill,
                       input logic [3:0] ecode, input logic eill);
    n_cmp++;
    if (code !== ecode || ill !== eill) begin
      n_fail++;
      $display("FAIL %s: got ALUInp=%b illegal=%b, want ALUInp=%b illegal=%b",
               name, code, ill, ecode, eill);
    end
  endtask

  task automatic drive_push(input vec_t v);
    bus.ALUOp  = v.aluop;
    bus.opcode = v.opc;
    sb.push_back(v);
  endtask

  task automatic edge_check();
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, want one pending entry");
    end else begin
      e = sb.pop_front();
      check(e.name, bus.ALUInp, bus.illegal, e.code, e.ill);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] a, input logic [5:0] o,
                              input logic [3:0] c, input logic i);
    vec_t v;
    v.name = n; v.aluop = a; v.opc = o; v.code = c; v.ill = i;
    return v;
  endfunction

  logic [3:0] rtype_exp [10];
  logic [5:0] bad_opc [3];
  logic [5:0] fixed_opc [2];

  initial begin
    rtype_exp = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                  4'b1100, 4'b0111, 4'b1000, 4'b1001, 4'b1010};
    bad_opc   = '{6'd10, 6'd32, 6'd63};
    fixed_opc = '{6'd0, 6'd37};

    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 4; r++) vecs.push_back(mk("fixed_add", 2'd0, fixed_opc[k], 4'b0010, 1'b0));
      for (int r = 0; r < 4; r++) vecs.push_back(mk("fixed_sub", 2'd1, fixed_opc[k], 4'b0110, 1'b0));
      for (int r = 0; r < 4; r++) vecs.push_back(mk("fixed_slt", 2'd3, fixed_opc[k], 4'b0111, 1'b0));
    end
    for (int o = 0; o < 10; o++)
      vecs.push_back(mk($sformatf("rtype_%0d", o), 2'd2, 6'(o), rtype_exp[o], 1'b0));
    for (int b = 0; b < 3; b++)
      vecs.push_back(mk($sformatf("illegal_%0d", bad_opc[b]), 2'd2, bad_opc[b], 4'b0010, 1'b1));
    vecs.push_back(mk("illegal_clear", 2'd0, 6'd63, 4'b0010, 1'b0));

    // Reset held with SUB class present; output must stay at ADD
    bus.ALUOp  = 2'd1;
    bus.opcode = 6'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_async", bus.ALUInp, bus.illegal, 4'b0010, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1 check("reset_hold", bus.ALUInp, bus.illegal, 4'b0010, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(mk("reset_release", 2'd1, 6'd0, 4'b0110, 1'b0));
    edge_check();

    foreach (vecs[i]) begin
      drive_push(vecs[i]);
      edge_check();
    end

    // Selector changes between edges; only the value at the edge is captured
    bus.ALUOp  = 2'd2;
    bus.opcode = 6'd5;
    #2 bus.opcode = 6'd7;
    #2 check("glitch_hold", bus.ALUInp, bus.illegal, 4'b0010, 1'b0);
    drive_push(mk("glitch_edge", 2'd2, 6'd3, 4'b0001, 1'b0));
    edge_check();

    for (int o = 0; o < 5; o++) begin
      drive_push(mk($sformatf("sweep2_%0d", o), 2'd2, 6'(o), rtype_exp[o], 1'b0));
      edge_check();
    end
    #2 rst_n = 1'b0;
    #1 check("midreset_async", bus.ALUInp, bus.illegal, 4'b0010, 1'b0);
    drive_push(mk("midreset_resume", 2'd2, 6'd5, 4'b1100, 1'b0));
    #1 rst_n = 1'b1;
    #1 check("midreset_pre_edge", bus.ALUInp, bus.illegal, 4'b0010, 1'b0);
    edge_check();
    for (int o = 6; o < 10; o++) begin
      drive_push(mk($sformatf("sweep2_%0d", o), 2'd2, 6'(o), rtype_exp[o], 1'b0));
      edge_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
